// File: rtl/alu_mul_seq.sv
// alu_mul_seq: iterative shift-add MUL sequencer that time-shares the EX-stage ALU adder
module alu_mul_seq #(
  parameter int          XLEN   = 32,
  parameter logic [3:0]  ADD_OP = 4'd0
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy,
  output logic [XLEN-1:0] o_alu_a,
  output logic [XLEN-1:0] o_alu_b,
  output logic [3:0]      o_alu_op,
  input  logic [XLEN-1:0] i_alu_data
);
  localparam int CW = $clog2(XLEN);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_nx;
  logic [XLEN-1:0] acc, mcand, mplier;
  logic [CW-1:0] cnt;
  logic accept, last, run;
  assign run    = state == RUN;
  assign accept = state == IDLE && i_valid && !i_flush;
  // Stop as soon as no multiplier bits remain above the one consumed this cycle.
  assign last   = mplier[XLEN-1:1] == '0 || cnt == CW'(XLEN-1);
  always_comb begin
    state_nx = state;
    state_nx = i_flush       ? IDLE
             : state == IDLE ? (i_valid ? (i_op_b != '0 ? RUN : DONE) : IDLE)
             : run           ? (last ? DONE : RUN)
             : (i_ready ? IDLE : DONE);
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        acc    <= '0;
        mcand  <= i_op_a;
        mplier <= i_op_b;
        cnt    <= '0;
      end else if (run) begin
        if (mplier[0]) acc <= i_alu_data;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
    end
  end
  assign o_ready  = state == IDLE && i_rst_n && !i_flush;
  assign o_valid  = state == DONE;
  assign o_busy   = state != IDLE;
  assign o_result = o_valid ? acc : '0;
  assign o_alu_a  = run ? acc : '0;
  assign o_alu_b  = run ? mcand : '0;
  assign o_alu_op = ADD_OP;
endmodule

// File: tb/tb_alu_mul_seq.sv
// tb_alu_mul_seq: randomized self-checking bench against an arithmetic MUL reference model
module tb_alu_mul_seq;
  logic        clk = 0, rst_n = 0, valid = 0, flush = 0, rdy = 0;
  logic [31:0] op_a = 0, op_b = 0, alu_data;
  logic        ready, ovalid, busy;
  logic [31:0] result, alu_a, alu_b;
  logic [3:0]  alu_op;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  // Behavioural ALU: only ADD is meaningful here; anything else yields a poison value.
  assign alu_data = alu_op == 4'd0 ? alu_a + alu_b : 32'hDEAD_BEEF;

  alu_mul_seq dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
    .i_op_a(op_a), .i_op_b(op_b), .i_flush(flush), .o_valid(ovalid),
    .i_ready(rdy), .o_result(result), .o_busy(busy), .o_alu_a(alu_a),
    .o_alu_b(alu_b), .o_alu_op(alu_op), .i_alu_data(alu_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int exp_latency(input logic [31:0] b);
    int top = -1;
    for (int i = 0; i < 32; i++) if (b[i]) top = i;
    return top + 2;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] prod;
    int cyc;
    prod = a * b;
    check("ready_idle", {31'd0, ready}, 32'd1);
    op_a = a; op_b = b; valid = 1; rdy = 0;
    tick();
    valid = 0; op_a = $urandom; op_b = $urandom;
    cyc = 1;
    while (!ovalid && cyc < 100) begin
      check("busy_run", {31'd0, busy}, 32'd1);
      check("alu_op", {28'd0, alu_op}, 32'd0);
      tick();
      cyc++;
    end
    check("latency", cyc, exp_latency(b));
    check("result", result, prod);
    if (b == 0) begin
      check("alu_a_zero", alu_a, 0);
      check("alu_b_zero", alu_b, 0);
    end
    for (int i = 0; i < hold; i++) begin
      valid = 1; op_a = $urandom; op_b = $urandom;
      tick();
      check("hold_valid", {31'd0, ovalid}, 32'd1);
      check("hold_result", result, prod);
      check("hold_ready", {31'd0, ready}, 32'd0);
    end
    valid = 0; rdy = 1;
    tick();
    rdy = 0;
    check("post_valid", {31'd0, ovalid}, 32'd0);
    check("post_busy", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [31:0] b;
    #12;
    check("rst_valid", {31'd0, ovalid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_result", result, 0);
    rst_n = 1;
    #2;
    check("rst_ready", {31'd0, ready}, 32'd1);
    tick();
    do_mul(3, 5, 0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    do_mul(32'h1234_5678, 0, 0);
    do_mul(7, 6, 5);
    // Flush partway through a long run; no result may ever appear.
    op_a = 9; op_b = 32'h8000_0000; valid = 1;
    tick();
    valid = 0;
    repeat (9) tick();
    check("flush_busy_pre", {31'd0, busy}, 32'd1);
    flush = 1;
    tick();
    flush = 0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_valid", {31'd0, ovalid}, 32'd0);
    begin
      int seen = 0;
      repeat (40) begin tick(); seen |= int'(ovalid); end
      check("flush_no_valid", seen, 0);
    end
    do_mul(2, 2, 0);
    // Asynchronous reset in the fourth RUN cycle.
    op_a = 1; op_b = 32'hFF; valid = 1;
    tick();
    valid = 0;
    repeat (3) tick();
    #2 rst_n = 0;
    #1;
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_valid", {31'd0, ovalid}, 32'd0);
    check("arst_result", result, 0);
    check("arst_alu_a", alu_a, 0);
    check("arst_alu_b", alu_b, 0);
    #3 rst_n = 1;
    #1;
    check("arst_ready", {31'd0, ready}, 32'd1);
    tick();
    do_mul(1, 32'hFF, 1);
    for (int i = 0; i < 40; i++) begin
      b = (i % 8 == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      do_mul($urandom, b, $urandom_range(0, 3));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
